// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - register-file widths and the write-back request type
package cpu_pkg;
   localparam int REG_W      = 16;
   localparam int REG_ADDR_W = 3;
   localparam int NUM_REGS   = 8;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_W-1:0]      data;
   } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - pipeline, accelerator and register-file signals of the write-back arbiter
interface wb_arbiter_if;
   import cpu_pkg::*;

   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [REG_W-1:0]      wb_data;
   logic                  wb_stall;
   logic                  acc_valid;
   logic [REG_ADDR_W-1:0] acc_rd;
   logic [REG_W-1:0]      acc_data;
   logic                  acc_ready;
   logic                  reg_write;
   logic [REG_ADDR_W-1:0] reg_rd;
   logic [REG_W-1:0]      reg_wdata;
   logic [NUM_REGS-1:0]   pend_mask;
   logic                  waw_err;

   modport master (
      output wb_valid, wb_rd, wb_data, acc_valid, acc_rd, acc_data,
      input  wb_stall, acc_ready, reg_write, reg_rd, reg_wdata, pend_mask, waw_err
   );

   modport slave (
      input  wb_valid, wb_rd, wb_data, acc_valid, acc_rd, acc_data,
      output wb_stall, acc_ready, reg_write, reg_rd, reg_wdata, pend_mask, waw_err
   );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - accelerator result FIFO exposing per-slot valid and rd for the pending mask
module wb_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  wb_req_t                     wr_req,
   output wb_req_t                     head,
   output logic                        full,
   output logic                        empty,
   output logic [DEPTH-1:0]            ent_valid,
   output logic [DEPTH*REG_ADDR_W-1:0] ent_rd
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   wb_req_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [DEPTH-1:0] vld;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign ent_valid = vld;

   for (genvar i = 0; i < DEPTH; i++) begin : g_rd
      assign ent_rd[i*REG_ADDR_W +: REG_ADDR_W] = mem[i].rd;
   end

   // Push and pop never address the same slot: that needs both full and empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_req;
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges pipeline write-back and buffered accelerator results onto the regfile write port
module wb_arbiter
   import cpu_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic          clk,
   input logic          rst,
   wb_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   wb_req_t                     head;
   wb_req_t                     acc_req;
   logic                        full;
   logic                        empty;
   logic [DEPTH-1:0]            ent_valid;
   logic [DEPTH*REG_ADDR_W-1:0] ent_rd;
   logic [SW-1:0]               starve_cnt;
   logic                        force_pop;
   logic                        take_wb;
   logic                        pop;
   logic                        push;
   logic [NUM_REGS-1:0]         pend;
   logic                        reg_write_q;
   logic [REG_ADDR_W-1:0]       reg_rd_q;
   logic [REG_W-1:0]            reg_wdata_q;
   logic                        out_acc;
   logic                        waw_q;

   assign acc_req   = '{rd: bus.acc_rd, data: bus.acc_data};
   assign push      = bus.acc_valid && !full;
   // Forced pop depends only on registered state, so wb_stall has no path from wb_valid.
   assign force_pop = !empty && (starve_cnt == LIMIT);
   assign take_wb   = bus.wb_valid && !force_pop;
   assign pop       = force_pop || (!bus.wb_valid && !empty);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .wr_req    (acc_req),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd)
   );

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i]) pend[ent_rd[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
      end
      if (reg_write_q && out_acc) pend[reg_rd_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt  <= '0;
         reg_write_q <= 1'b0;
         reg_rd_q    <= '0;
         reg_wdata_q <= '0;
         out_acc     <= 1'b0;
         waw_q       <= 1'b0;
      end else begin
         reg_write_q <= take_wb || pop;
         out_acc     <= pop;
         if (take_wb) begin
            reg_rd_q    <= bus.wb_rd;
            reg_wdata_q <= bus.wb_data;
         end else if (pop) begin
            reg_rd_q    <= head.rd;
            reg_wdata_q <= head.data;
         end
         if (take_wb && pend[bus.wb_rd]) waw_q <= 1'b1;
         if (pop || empty) starve_cnt <= '0;
         else if (take_wb && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign bus.wb_stall  = force_pop;
   assign bus.acc_ready = !full;
   assign bus.reg_write = reg_write_q;
   assign bus.reg_rd    = reg_rd_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.pend_mask = pend;
   assign bus.waw_err   = waw_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
   import cpu_pkg::*;

   localparam int DEPTH = 4;
   localparam int LIM   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_arbiter_if bus();

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Reference model: a queue of pending results plus the expected write-port registers.
   wb_req_t        q[$];
   int             starve = 0;
   logic           m_rw = 1'b0;
   logic [2:0]     m_rd = '0;
   logic [15:0]    m_data = '0;
   logic           m_acc = 1'b0;
   logic           m_waw = 1'b0;
   logic [15:0]    got[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_pend();
      logic [7:0] m;
      m = '0;
      foreach (q[i]) m[q[i].rd] = 1'b1;
      if (m_rw && m_acc) m[m_rd] = 1'b1;
      return m;
   endfunction

   task automatic drive(input logic wv, input logic [2:0] wrd, input logic [15:0] wd,
                        input logic av, input logic [2:0] ard, input logic [15:0] ad);
      bus.wb_valid  = wv;
      bus.wb_rd     = wrd;
      bus.wb_data   = wd;
      bus.acc_valid = av;
      bus.acc_rd    = ard;
      bus.acc_data  = ad;
   endtask

   task automatic step();
      logic emp, frc, rdy, tk, pp;
      logic [7:0] pm;
      wb_req_t hd;
      emp = (q.size() == 0);
      frc = !emp && (starve == LIM);
      rdy = (q.size() < DEPTH);
      pm  = m_pend();
      if (!rst) begin
         check("wb_stall",  32'(bus.wb_stall),  32'(frc));
         check("acc_ready", 32'(bus.acc_ready), 32'(rdy));
         check("pend_mask", 32'(bus.pend_mask), 32'(pm));
      end
      tk = bus.wb_valid && !frc;
      pp = frc || (!bus.wb_valid && !emp);
      @(posedge clk);
      if (rst) begin
         q.delete();
         starve = 0;
         m_rw = 1'b0; m_rd = '0; m_data = '0; m_acc = 1'b0; m_waw = 1'b0;
      end else begin
         if (tk && pm[bus.wb_rd]) m_waw = 1'b1;
         m_rw  = tk || pp;
         m_acc = pp;
         if (tk) begin
            m_rd = bus.wb_rd; m_data = bus.wb_data;
         end else if (pp) begin
            hd = q.pop_front();
            m_rd = hd.rd; m_data = hd.data;
         end
         if (bus.acc_valid && rdy) q.push_back('{rd: bus.acc_rd, data: bus.acc_data});
         if (pp || emp) starve = 0;
         else if (tk && starve < LIM) starve++;
      end
      #1;
      check("reg_write", 32'(bus.reg_write), 32'(m_rw));
      check("reg_rd",    32'(bus.reg_rd),    32'(m_rd));
      check("reg_wdata", 32'(bus.reg_wdata), 32'(m_data));
      check("waw_err",   32'(bus.waw_err),   32'(m_waw));
      if (bus.reg_write) got.push_back(bus.reg_wdata);
   endtask

   initial begin
      logic [15:0] exp_seq[$];
      logic [15:0] n;
      int stalls;

      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_reg_write", 32'(bus.reg_write), 32'd0);
      check("rst_pend",      32'(bus.pend_mask), 32'd0);
      check("rst_acc_ready", 32'(bus.acc_ready), 32'd1);
      check("rst_wb_stall",  32'(bus.wb_stall),  32'd0);

      // Pipeline only
      drive(1, 3, 16'hBEEF, 0, 0, 0);
      step();
      check("t1_write", 32'(bus.reg_write), 32'd1);
      check("t1_rd",    32'(bus.reg_rd),    32'd3);
      check("t1_data",  32'(bus.reg_wdata), 32'hBEEF);
      drive(0, 0, 0, 0, 0, 0);
      step();

      // Accelerator only
      drive(0, 0, 0, 1, 5, 16'h1234);
      step();
      drive(0, 0, 0, 0, 0, 0);
      check("t2_pend_c1", 32'(bus.pend_mask), 32'h20);
      step();
      check("t2_write_c2", 32'(bus.reg_write), 32'd1);
      check("t2_data_c2",  32'(bus.reg_wdata), 32'h1234);
      check("t2_pend_c2",  32'(bus.pend_mask), 32'h20);
      step();
      check("t2_pend_c3", 32'(bus.pend_mask), 32'h00);

      // Fill with pipeline WB held high
      for (int i = 0; i < 4; i++) begin
         drive(1, 7, 16'h0A00 + 16'(i), 1, 3'(i), 16'hA000 + 16'(i));
         step();
      end
      check("t3_acc_ready", 32'(bus.acc_ready), 32'd0);
      drive(1, 7, 16'h0A10, 1, 4, 16'hA004);
      step();
      step();
      check("t3_pend_full", 32'(bus.pend_mask), 32'h0F);
      for (int i = 0; i < 8; i++) step();
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step();

      // Starvation: one queued entry, continuous pipeline WB
      got.delete();
      stalls = 0;
      n = 16'h0100;
      drive(1, 1, n, 1, 6, 16'hCAFE);
      step();
      for (int i = 0; i < 11; i++) begin
         if (!bus.wb_stall) n = n + 1'b1;
         else stalls++;
         drive(1, 1, n, 0, 0, 0);
         step();
      end
      for (int i = 0; i <= 8; i++) exp_seq.push_back(16'h0100 + 16'(i));
      exp_seq.push_back(16'hCAFE);
      exp_seq.push_back(16'h0109);
      exp_seq.push_back(16'h010A);
      check("t4_nwrites", 32'(got.size()), 32'(exp_seq.size()));
      for (int i = 0; i < exp_seq.size() && i < got.size(); i++)
         check($sformatf("t4_seq%0d", i), 32'(got[i]), 32'(exp_seq[i]));
      check("t4_stalls", 32'(stalls), 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      step();

      // WAW
      drive(1, 4, 16'h4444, 0, 0, 0);
      step();
      check("t5_no_waw", 32'(bus.waw_err), 32'd0);
      drive(1, 0, 16'h0000, 1, 2, 16'h2222);
      step();
      drive(1, 2, 16'h2020, 0, 0, 0);
      step();
      check("t5_waw_set", 32'(bus.waw_err), 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step();
      check("t5_waw_sticky", 32'(bus.waw_err), 32'd1);

      // Reset mid-operation
      for (int i = 0; i < 3; i++) begin
         drive(1, 7, 16'h7000, 1, 3'(i), 16'hB000 + 16'(i));
         step();
      end
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_pend",      32'(bus.pend_mask), 32'd0);
      check("t6_reg_write", 32'(bus.reg_write), 32'd0);
      check("t6_acc_ready", 32'(bus.acc_ready), 32'd1);
      check("t6_waw",       32'(bus.waw_err),   32'd0);

      // Randomized traffic obeying the hold rules
      for (int i = 0; i < 600; i++) begin
         if (!(bus.wb_valid && bus.wb_stall)) begin
            bus.wb_valid = ($urandom_range(0, 99) < 60);
            bus.wb_rd    = 3'($urandom);
            bus.wb_data  = 16'($urandom);
         end
         if (!(bus.acc_valid && !bus.acc_ready)) begin
            bus.acc_valid = ($urandom_range(0, 99) < 45);
            bus.acc_rd    = 3'($urandom);
            bus.acc_data  = 16'($urandom);
         end
         rst = ($urandom_range(0, 199) == 0);
         step();
         rst = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
